// File: rtl/hpi_responder.sv
// hpi_responder: device side of a 4-register HPI bus (DATA window, MAILBOX, ADDRESS, STATUS).
// Host strobes are synchronised into Clk; OTG_DATA is driven only while the host reads.
`timescale 1ns/1ps
module hpi_responder #(
    parameter int MEM_AW = 8
) (
    input  logic              Clk,
    input  logic              Reset_n,
    inout  wire  [15:0]       OTG_DATA,
    input  logic [1:0]        OTG_ADDR,
    input  logic              OTG_CS_N,
    input  logic              OTG_RD_N,
    input  logic              OTG_WR_N,
    input  logic              OTG_RST_N,
    output logic              OTG_INT,
    input  logic [MEM_AW-1:0] dev_addr,
    output logic [15:0]       dev_rdata,
    output logic              dev_h2d_valid,
    output logic [15:0]       dev_h2d_data,
    input  logic              dev_h2d_ack,
    input  logic              dev_d2h_wr,
    input  logic [15:0]       dev_d2h_wdata,
    output logic              dev_d2h_busy
);
    localparam int PW = MEM_AW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_WRITE
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        cs_n_sync_q, rd_n_sync_q, wr_n_sync_q;
    logic [1:0]        addr_meta_q, addr_sync_q;
    logic [15:0]       data_meta_q, data_sync_q;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [15:0]       h2d_q, h2d_d, d2h_q, d2h_d;
    logic              h2d_full_q, h2d_full_d, d2h_full_q, d2h_full_d;
    logic              overrun_q, overrun_d;
    logic [15:0]       rdata_q, rdata_d;
    logic              drive_q, drive_d;
    logic [1:0]        op_addr_q, op_addr_d;
    logic [15:0]       dev_rdata_q;
    logic              mem_we;
    logic              cs, rd, wr;
    logic [MEM_AW-1:0] widx;
    logic [15:0]       mem [2**MEM_AW];

    assign cs   = ~cs_n_sync_q[1];
    assign rd   = ~rd_n_sync_q[1];
    assign wr   = ~wr_n_sync_q[1];
    assign widx = ptr_q[MEM_AW:1];

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        h2d_d      = h2d_q;
        d2h_d      = d2h_q;
        h2d_full_d = h2d_full_q;
        d2h_full_d = d2h_full_q;
        overrun_d  = overrun_q;
        rdata_d    = rdata_q;
        drive_d    = drive_q;
        op_addr_d  = op_addr_q;
        mem_we     = 1'b0;

        // Device ack is applied first so a same-cycle host mailbox write leaves the new word valid.
        if (dev_h2d_ack) h2d_full_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cs && rd) begin
                    state_d   = S_READ;
                    drive_d   = 1'b1;
                    op_addr_d = addr_sync_q;
                    case (addr_sync_q)
                        2'd0:    rdata_d = mem[widx];
                        2'd1:    rdata_d = d2h_q;
                        2'd2:    rdata_d = 16'(ptr_q);
                        default: rdata_d = {13'b0, overrun_q, d2h_full_q, h2d_full_q};
                    endcase
                end else if (cs && wr) begin
                    state_d = S_WRITE;
                end
            end
            S_READ: begin
                // Strobe end has priority over CS so a simultaneous release completes the cycle.
                if (!rd) begin
                    state_d = S_IDLE;
                    drive_d = 1'b0;
                    case (op_addr_q)
                        2'd0:    ptr_d = ptr_q + PW'(2);
                        2'd1:    d2h_full_d = 1'b0;
                        default: ;
                    endcase
                end else if (!cs) begin
                    state_d = S_IDLE;
                    drive_d = 1'b0;
                end
            end
            S_WRITE: begin
                if (!wr) begin
                    state_d = S_IDLE;
                    case (addr_sync_q)
                        2'd0: begin
                            mem_we = 1'b1;
                            ptr_d  = ptr_q + PW'(2);
                        end
                        2'd1: begin
                            if (h2d_full_q && !dev_h2d_ack) overrun_d = 1'b1;
                            h2d_d      = data_sync_q;
                            h2d_full_d = 1'b1;
                        end
                        2'd2:    ptr_d = {data_sync_q[MEM_AW:1], 1'b0};
                        default: overrun_d = 1'b0;
                    endcase
                end else if (!cs) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (dev_d2h_wr && !d2h_full_d) begin
            d2h_d      = dev_d2h_wdata;
            d2h_full_d = 1'b1;
        end

        if (!OTG_RST_N) begin
            state_d    = S_IDLE;
            ptr_d      = '0;
            h2d_d      = '0;
            d2h_d      = '0;
            h2d_full_d = 1'b0;
            d2h_full_d = 1'b0;
            overrun_d  = 1'b0;
            drive_d    = 1'b0;
            mem_we     = 1'b0;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cs_n_sync_q <= 2'b11;
            rd_n_sync_q <= 2'b11;
            wr_n_sync_q <= 2'b11;
            addr_meta_q <= '0;
            addr_sync_q <= '0;
            data_meta_q <= '0;
            data_sync_q <= '0;
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            h2d_q       <= '0;
            d2h_q       <= '0;
            h2d_full_q  <= 1'b0;
            d2h_full_q  <= 1'b0;
            overrun_q   <= 1'b0;
            rdata_q     <= '0;
            drive_q     <= 1'b0;
            op_addr_q   <= '0;
            dev_rdata_q <= '0;
        end else begin
            cs_n_sync_q <= {cs_n_sync_q[0], OTG_CS_N};
            rd_n_sync_q <= {rd_n_sync_q[0], OTG_RD_N};
            wr_n_sync_q <= {wr_n_sync_q[0], OTG_WR_N};
            addr_meta_q <= OTG_ADDR;
            addr_sync_q <= addr_meta_q;
            data_meta_q <= OTG_DATA;
            data_sync_q <= data_meta_q;
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            h2d_q       <= h2d_d;
            d2h_q       <= d2h_d;
            h2d_full_q  <= h2d_full_d;
            d2h_full_q  <= d2h_full_d;
            overrun_q   <= overrun_d;
            rdata_q     <= rdata_d;
            drive_q     <= drive_d;
            op_addr_q   <= op_addr_d;
            dev_rdata_q <= mem[dev_addr];
        end
    end

    always_ff @(posedge Clk) begin
        if (mem_we) mem[widx] <= data_sync_q;
    end

    // Raw strobes gate the driver so the bus is released without waiting for the synchronisers.
    assign OTG_DATA      = (drive_q && !OTG_CS_N && !OTG_RD_N) ? rdata_q : 16'hzzzz;
    assign OTG_INT       = d2h_full_q;
    assign dev_rdata     = dev_rdata_q;
    assign dev_h2d_valid = h2d_full_q;
    assign dev_h2d_data  = h2d_q;
    assign dev_d2h_busy  = d2h_full_q;

endmodule
